// File: rtl/ysyx_idu_ibuf.sv
// Instruction buffer between fetch and decode: a small circular FIFO plus a RUN/HOLD sequencer.
// After a serializing head (SYSTEM, FENCE.I, C.EBREAK, fetch trap) issues, decode waits for retire.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_idu_ibuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = `YSYX_XLEN
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush_pipe,
    input  logic                    serial_done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_pnpc,
    input  logic                    in_trap,
    input  logic [XLEN-1:0]         in_cause,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_pnpc,
    output logic                    out_trap,
    output logic [XLEN-1:0]         out_cause,
    output logic [$clog2(DEPTH):0]  out_count,
    output logic [31:0]             serial_stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [AW:0]     r_rptr;
    logic [AW:0]     r_wptr;
    logic [AW:0]     w_count;
    logic [31:0]     r_stall;
    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;
    logic            w_serial;

    logic [31:0]     r_inst  [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_pnpc  [DEPTH];
    logic            r_trap  [DEPTH];
    logic [XLEN-1:0] r_cause [DEPTH];

    // Pointers carry a wrap bit, so the plain difference is the occupancy.
    assign w_count   = r_wptr - r_rptr;
    assign w_full    = (w_count == CntFull);
    assign w_empty   = (w_count == '0);
    assign in_ready  = !w_full && !flush_pipe;
    assign out_valid = !w_empty && (r_state == StRun) && !flush_pipe;
    assign w_enq     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;

    assign out_inst  = r_inst[r_rptr[AW-1:0]];
    assign out_pc    = r_pc[r_rptr[AW-1:0]];
    assign out_pnpc  = r_pnpc[r_rptr[AW-1:0]];
    assign out_trap  = r_trap[r_rptr[AW-1:0]];
    assign out_cause = r_cause[r_rptr[AW-1:0]];
    assign out_count = w_count;
    assign serial_stall_cnt = r_stall;

    assign w_serial = (out_inst[6:0] == 7'b1110011)
                    || (out_inst[6:0] == 7'b0001111 && out_inst[14:12] == 3'b001)
                    || (out_inst[15:0] == 16'h9002)
                    || out_trap;

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_inst[r_wptr[AW-1:0]]  <= in_inst;
            r_pc[r_wptr[AW-1:0]]    <= in_pc;
            r_pnpc[r_wptr[AW-1:0]]  <= in_pnpc;
            r_trap[r_wptr[AW-1:0]]  <= in_trap;
            r_cause[r_wptr[AW-1:0]] <= in_cause;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr <= '0;
            r_wptr <= '0;
        end else if (flush_pipe) begin
            r_rptr <= '0;
            r_wptr <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_pipe) begin
            w_state_next = StRun;
        end else begin
            unique case (r_state)
                StRun:   if (w_deq && w_serial) w_state_next = StHold;
                StHold:  if (serial_done) w_state_next = StRun;
                default: w_state_next = StRun;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall counter survives flushes; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (r_state == StHold && r_stall != 32'hFFFF_FFFF) begin
            r_stall <= r_stall + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_idu_ibuf.sv
// Self-checking bench for ysyx_idu_ibuf: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_ysyx_idu_ibuf;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush_pipe = 1'b0;
    logic        serial_done = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_pnpc = '0;
    logic        in_trap = 1'b0;
    logic [31:0] in_cause = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pnpc;
    logic        out_trap;
    logic [31:0] out_cause;
    logic [2:0]  out_count;
    logic [31:0] serial_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pnpc;
        logic        trap;
        logic [31:0] cause;
    } ent_t;

    ent_t        mq[$];
    bit          m_hold;
    logic [31:0] m_stall;

    ysyx_idu_ibuf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .flush_pipe(flush_pipe), .serial_done(serial_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_pnpc(in_pnpc), .in_trap(in_trap), .in_cause(in_cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_pnpc(out_pnpc), .out_trap(out_trap), .out_cause(out_cause),
        .out_count(out_count), .serial_stall_cnt(serial_stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush_pipe = 1'b0; serial_done = 1'b0;
        in_inst = '0; in_pc = '0; in_pnpc = '0; in_trap = 1'b0; in_cause = '0;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic trap, input logic [31:0] cause);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; in_pnpc = pc + 32'd4;
        in_trap = trap; in_cause = cause;
    endtask

    function automatic bit is_serial(input ent_t e);
        logic [31:0] i;
        i = e.inst;
        return (i[6:0] == 7'b1110011) || (i[6:0] == 7'b0001111 && i[14:12] == 3'b001)
            || (i[15:0] == 16'h9002) || e.trap;
    endfunction

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #12 reset = 1'b0;
        #2;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", out_count); end
        n_tests++; if (serial_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", serial_stall_cnt); end
        cyc();
    endtask

    task automatic test_basic_flow();
        idle();
        out_ready = 1'b1;
        drive(32'h0000_0013, 32'h8000_0000, 1'b0, '0);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got %b want 0", out_valid); end
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        n_tests++; if (out_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_out_pc got %h want 80000000", out_pc); end
        n_tests++; if (out_pnpc !== 32'h8000_0004) begin n_fail++; $display("FAIL basic_out_pnpc got %h want 80000004", out_pnpc); end
        n_tests++; if (out_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_out_inst got %h want 00000013", out_inst); end
        n_tests++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL basic_count1 got %0d want 1", out_count); end
        cyc();
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL basic_count0 got %0d want 0", out_count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b want 0", out_valid); end
    endtask

    task automatic test_fill_backpressure();
        idle();
        for (int i = 0; i < 5; i++) begin
            drive(32'h0000_0013, 32'(4 * i), 1'b0, '0);
            #1;
            n_tests++;
            if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_in_ready[%0d] got %b want %b", i, in_ready, (i < 4)); end
            if (i < 4) cyc();
        end
        n_tests++; if (out_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", out_count); end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_deq_ready got %b want 0", in_ready); end
        for (int j = 0; j < 5; j++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * j)) begin
                n_fail++; $display("FAIL drain_order[%0d] got v=%b pc=%h want v=1 pc=%h", j, out_valid, out_pc, 32'(4 * j));
            end
            if (j == 1) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_slot_free got %b want 1", in_ready); end
            end
            cyc();
            if (j >= 1) in_valid = 1'b0;
            #1;
        end
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", out_count); end
    endtask

    task automatic test_serialization();
        idle();
        drive(32'h3057_1073, 32'h100, 1'b0, '0);
        cyc();
        drive(32'h0010_0093, 32'h104, 1'b0, '0);
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_inst !== 32'h3057_1073) begin n_fail++; $display("FAIL ser_issue got v=%b inst=%h want v=1 inst=30571073", out_valid, out_inst); end
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ser_hold[%0d] got %b want 0", k, out_valid); end
            if (k == 2) serial_done = 1'b1;
            cyc();
        end
        serial_done = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin n_fail++; $display("FAIL ser_resume got v=%b pc=%h want v=1 pc=104", out_valid, out_pc); end
        n_tests++; if (serial_stall_cnt !== 32'd3) begin n_fail++; $display("FAIL ser_stall_cnt got %0d want 3", serial_stall_cnt); end
        cyc();
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL ser_drained got %0d want 0", out_count); end
    endtask

    task automatic test_compressed_trap();
        logic [31:0] insts [3];
        logic        traps [3];
        bit          holds [3];
        insts[0] = 32'h0000_9002; traps[0] = 1'b0; holds[0] = 1'b1;
        insts[1] = 32'h0000_0001; traps[1] = 1'b0; holds[1] = 1'b0;
        insts[2] = 32'h0000_0013; traps[2] = 1'b1; holds[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle();
            drive(insts[c], 32'h200, traps[c], {31'd0, traps[c]});
            cyc();
            drive(32'h0000_0013, 32'h204, 1'b0, '0);
            cyc();
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            n_tests++; if (out_valid !== 1'b1 || out_inst !== insts[c]) begin n_fail++; $display("FAIL ctrap_issue[%0d] got v=%b inst=%h want v=1 inst=%h", c, out_valid, out_inst, insts[c]); end
            if (traps[c]) begin
                n_tests++; if (out_trap !== 1'b1 || out_cause !== 32'd1) begin n_fail++; $display("FAIL ctrap_cause got trap=%b cause=%h want 1/1", out_trap, out_cause); end
            end
            cyc();
            n_tests++; if (out_valid !== !holds[c]) begin n_fail++; $display("FAIL ctrap_hold[%0d] got out_valid=%b want %b", c, out_valid, !holds[c]); end
            if (holds[c]) begin
                serial_done = 1'b1;
                cyc();
                serial_done = 1'b0;
                #1;
            end
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin n_fail++; $display("FAIL ctrap_next[%0d] got v=%b pc=%h want v=1 pc=204", c, out_valid, out_pc); end
            cyc();
        end
    endtask

    task automatic test_flush();
        idle();
        drive(32'h0000_0073, 32'h300, 1'b0, '0);
        cyc();
        drive(32'h0000_0013, 32'h304, 1'b0, '0);
        out_ready = 1'b1;
        cyc();
        drive(32'h0000_0013, 32'h308, 1'b0, '0);
        cyc();
        drive(32'h0000_0013, 32'h30C, 1'b0, '0);
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_count !== 3'd3 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pre got cnt=%0d v=%b want cnt=3 v=0", out_count, out_valid); end
        flush_pipe = 1'b1;
        drive(32'h0000_0013, 32'h310, 1'b0, '0);
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        cyc();
        flush_pipe = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (out_count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post got cnt=%0d v=%b want cnt=0 v=0", out_count, out_valid); end
        drive(32'h0000_0013, 32'h400, 1'b0, '0);
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin n_fail++; $display("FAIL flush_run got v=%b pc=%h want v=1 pc=400", out_valid, out_pc); end
        cyc();
    endtask

    task automatic test_async_reset();
        idle();
        drive(32'h0000_0013, 32'h500, 1'b0, '0);
        cyc();
        drive(32'h0000_0013, 32'h504, 1'b0, '0);
        cyc();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL areset_pre got %0d want 2", out_count); end
        #3 reset = 1'b1;
        #1;
        n_tests++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", out_count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", out_valid); end
        n_tests++; if (serial_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL areset_stall got %0d want 0", serial_stall_cnt); end
        #1 reset = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        ent_t        cur;
        ent_t        head;
        logic [31:0] r;
        bit          exp_rdy, exp_ov, deq, ser;
        idle();
        reset = 1'b1;
        #2 reset = 1'b0;
        mq.delete(); m_hold = 1'b0; m_stall = '0;
        cyc();
        for (int t = 0; t < 3000; t++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0:       cur.inst = {r[31:7], 7'b1110011};
                1:       cur.inst = {r[31:15], 3'b001, r[11:7], 7'b0001111};
                2:       cur.inst = {r[31:16], 16'h9002};
                3:       cur.inst = {r[31:15], 3'b000, r[11:7], 7'b0001111};
                default: cur.inst = r;
            endcase
            cur.pc = $urandom; cur.pnpc = $urandom; cur.cause = $urandom;
            cur.trap = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            in_inst = cur.inst; in_pc = cur.pc; in_pnpc = cur.pnpc;
            in_trap = cur.trap; in_cause = cur.cause;
            out_ready = ($urandom_range(0, 9) < 6);
            flush_pipe = ($urandom_range(0, 39) == 0);
            serial_done = ($urandom_range(0, 3) == 0);
            #1;
            exp_rdy = (mq.size() < DEPTH) && !flush_pipe;
            exp_ov  = (mq.size() > 0) && !m_hold && !flush_pipe;
            n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready@%0d got %b want %b", t, in_ready, exp_rdy); end
            n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_out_valid@%0d got %b want %b", t, out_valid, exp_ov); end
            n_tests++; if (out_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d got %0d want %0d", t, out_count, mq.size()); end
            n_tests++; if (serial_stall_cnt !== m_stall) begin n_fail++; $display("FAIL rnd_stall@%0d got %0d want %0d", t, serial_stall_cnt, m_stall); end
            if (exp_ov) begin
                head = mq[0];
                n_tests++;
                if (out_inst !== head.inst || out_pc !== head.pc || out_pnpc !== head.pnpc
                    || out_trap !== head.trap || out_cause !== head.cause) begin
                    n_fail++;
                    $display("FAIL rnd_head@%0d got %h/%h/%h/%b/%h want %h/%h/%h/%b/%h", t,
                             out_inst, out_pc, out_pnpc, out_trap, out_cause,
                             head.inst, head.pc, head.pnpc, head.trap, head.cause);
                end
            end
            if (m_hold && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (flush_pipe) begin
                mq.delete();
                m_hold = 1'b0;
            end else begin
                deq = exp_ov && out_ready;
                ser = 1'b0;
                if (deq) begin
                    ser = is_serial(mq[0]);
                    void'(mq.pop_front());
                end
                if (in_valid && exp_rdy) mq.push_back(cur);
                if (m_hold) begin
                    if (serial_done) m_hold = 1'b0;
                end else if (deq && ser) begin
                    m_hold = 1'b1;
                end
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_flow();
        test_fill_backpressure();
        test_serialization();
        test_compressed_trap();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_idu_ibuf.md
Name: ysyx_idu_ibuf

Overview:
- Instruction buffer and issue sequencer between the fetch unit and the decode stage.
- Decouples fetch from decode back-pressure with a small FIFO.
- Enforces serialization: after a serializing instruction (SYSTEM, FENCE.I, C.EBREAK, or a fetch trap) is handed to decode, further issue is held until the commit unit reports it retired.
- A pipeline flush empties the buffer and clears any pending hold.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- XLEN, `YSYX_XLEN, width of pc, pnpc and cause.

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush_pipe  in  1  commit-unit pipeline flush.
- serial_done  in  1  commit unit: the outstanding serializing instruction has retired.
- in_valid  in  1  fetch entry valid.
- in_ready  out  1  buffer can accept an entry.
- in_inst  in  32  raw instruction; 16-bit instructions in [15:0].
- in_pc  in  XLEN  instruction pc.
- in_pnpc  in  XLEN  predicted next pc.
- in_trap  in  1  fetch fault.
- in_cause  in  XLEN  fetch fault cause.
- out_valid  out  1  head entry offered to decode.
- out_ready  in  1  decode accepts.
- out_inst, out_pc, out_pnpc, out_trap, out_cause  out  32/XLEN/XLEN/1/XLEN  head entry fields.
- out_count  out  $clog2(DEPTH)+1  current occupancy.
- serial_stall_cnt  out  32  saturating count of cycles spent in HOLD.

Behaviour:
- Storage: circular FIFO with read and write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Pointers wrap modulo 2*DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- in_ready = !full && !flush_pipe. Purely combinational; it does not depend on out_ready, so a full buffer never accepts, even when a dequeue occurs in the same cycle.
- Enqueue when in_valid && in_ready: write all fields at wptr, then wptr++.
- State machine, states RUN and HOLD:
  - out_valid = !empty && state == RUN && !flush_pipe.
  - Output fields always reflect the head entry; they are don't-care when out_valid = 0.
  - Dequeue when out_valid && out_ready: rptr++.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Serializing entry, evaluated on the dequeued head:
  - inst[1:0] == 2'b11 and inst[6:0] == 7'b1110011 (SYSTEM); or
  - inst[1:0] == 2'b11, inst[6:0] == 7'b0001111 and inst[14:12] == 3'b001 (FENCE.I); or
  - inst[15:0] == 16'h9002 (C.EBREAK); or
  - trap == 1.
- Transitions:
  - RUN -> HOLD on the cycle after a serializing entry is dequeued.
  - HOLD -> RUN on serial_done.
  - serial_done while in RUN is ignored.
  - While in HOLD, enqueue continues until the buffer is full.
- Flush has the highest priority:
  - Next cycle: rptr = wptr = 0 and state = RUN.
  - Enqueue and dequeue are both suppressed in the flush cycle, via the in_ready and out_valid gating above.
  - serial_done in the same cycle is ignored.
- serial_stall_cnt:
  - Increments by 1 each cycle state == HOLD.
  - Saturates at 32'hFFFF_FFFF.
  - Not cleared by flush.
- Reset (asynchronous): rptr = wptr = 0, state = RUN, serial_stall_cnt = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_count = 0.
  - FIFO payload is not reset.
  - Reset asserted mid-transfer discards all entries and any hold immediately, without waiting for a clock edge.
- Latency: an entry enqueued in cycle N can be offered at the earliest in cycle N+1 (no bypass).

Test Plan:
- Basic flow: enqueue 0x00000013 at pc 0x80000000 with out_ready = 1 -> out_valid = 1 one cycle later with out_pc = 0x80000000; out_count returns to 0 after the handshake.
- Fill and backpressure: out_ready = 0, push 5 entries with DEPTH = 4 -> in_ready = 0 after the 4th, out_count = 4. Release out_ready -> the entries drain in order pc 0x0, 0x4, 0x8, 0xC; the 5th enters only after a slot frees.
- Serialization: queue csrrw 0x30571073 followed by addi -> the csrrw is issued, then out_valid = 0 for 3 cycles until serial_done pulses; the addi is issued the cycle after serial_done; serial_stall_cnt = 3.
- Compressed and trap serialization:
  - 16'h9002 -> enters HOLD.
  - 16'h0001 (C.NOP) -> no hold.
  - An entry with in_trap = 1, in_cause = 1 -> HOLD, with out_cause = 1 presented.
- Flush: 3 entries queued while in HOLD, flush_pipe pulsed -> next cycle out_count = 0, state RUN, out_valid = 0. An in_valid entry presented in the flush cycle is not captured, because in_ready = 0.
- Async reset mid-operation: assert reset between clock edges with 2 entries queued -> out_count = 0 and out_valid = 0 immediately; serial_stall_cnt = 0.
